// File: rtl/clock_pkg.sv
// Shared time-base constants for the alarm-clock design's clock divider bank.
// CNT_W is limited to 32 bits so divisor arithmetic fits in an int unsigned.
package clock_pkg;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;

  localparam int unsigned DIV_1HZ  = SYS_CLK_HZ;
  localparam int unsigned DIV_1KHZ = SYS_CLK_HZ / 1_000;
  localparam int unsigned DIV_SCAN = SYS_CLK_HZ / 4_000;

  localparam int CNT_W_DEFAULT = 26;

  // High-phase length of the square wave: ceil(d/2), written so that d+1 cannot overflow.
  function automatic int unsigned ceil_half(input int unsigned d);
    return (d >> 1) + (d & 32'd1);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: an up-counter that wraps at DIV-1, a shadow divisor
// applied only at period boundaries, tick/square-wave outputs and a sticky error flag.
module clock_divider_channel
  import clock_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned RST_DIV = DIV_1HZ
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_clear_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_value_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             div_pending_o,
  output logic             cfg_err_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RST_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             load_zero;
  logic             terminal;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] div_next;

  assign load_ok   = div_load_i && (div_value_i != '0);
  assign load_zero = div_load_i && (div_value_i == '0);
  // >= rather than == so a corrupted count can never run on to the 2^CNT_W wrap
  assign terminal  = (count_q >= div_q - ONE);
  assign count_inc = count_q + ONE;
  // Divisor adopted at a period boundary: a same-edge load beats the shadow value.
  assign div_next  = load_ok ? div_value_i : (pending_q ? shadow_q : div_q);

  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    clk_d     = clk_q;
    err_d     = err_q | load_zero;

    if (sync_clear_i) begin
      count_d   = '0;
      div_d     = div_next;
      pending_d = 1'b0;
      if (en_i) begin
        clk_d = 1'b1;
      end
    end else if (en_i) begin
      if (terminal) begin
        count_d   = '0;
        tick_d    = 1'b1;
        div_d     = div_next;
        pending_d = 1'b0;
        clk_d     = 1'b1;
      end else begin
        count_d = count_inc;
        clk_d   = (32'(count_inc) < ceil_half(32'(div_q)));
        if (load_ok) begin
          shadow_d  = div_value_i;
          pending_d = 1'b1;
        end
      end
    end else if (load_ok) begin
      // An idle channel has no period in flight, so the new divisor takes effect at once.
      count_d   = '0;
      div_d     = div_value_i;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      div_q     <= DIV_RST;
      shadow_q  <= DIV_RST;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      clk_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
      err_q     <= err_d;
    end
  end

  assign tick_o        = tick_q;
  assign clk_o         = clk_q;
  assign div_pending_o = pending_q;
  assign cfg_err_o     = err_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent clock dividers on the 50 MHz board clock,
// sharing one divisor bus and one phase-align strobe.
module clock_divider_bank
  import clock_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clear,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] cfg_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i         (clk_in),
      .rst_ni        (rst_n),
      .en_i          (en[i]),
      .sync_clear_i  (sync_clear),
      .div_load_i    (div_load[i]),
      .div_value_i   (div_value),
      .tick_o        (tick_out[i]),
      .clk_o         (clk_out[i]),
      .div_pending_o (div_pending[i]),
      .cfg_err_o     (cfg_err[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with a reset divisor of 5; expected
// values are hand-computed edge by edge in the comments of each step.
module tb_clock_divider_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync_clear;
  logic [NUM_CH-1:0] div_load;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] div_pending;
  logic [NUM_CH-1:0] cfg_err;

  int checks = 0;
  int errors = 0;

  clock_divider_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (5)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sync_clear  (sync_clear),
    .div_load    (div_load),
    .div_value   (div_value),
    .tick_out    (tick_out),
    .clk_out     (clk_out),
    .div_pending (div_pending),
    .cfg_err     (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    en         = '0;
    sync_clear = 1'b0;
    div_load   = '0;
    div_value  = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tick", tick_out, 4'h0);
    chk("rst_clk", clk_out, 4'h0);
    chk("rst_pend", div_pending, 4'h0);
    chk("rst_err", cfg_err, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    en    = 4'hF;

    // 1: DIV=5, edges 1..15; count after edge k is k%5, clk high while count<3
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("t1_tick", tick_out, (k % 5 == 0) ? 4'hF : 4'h0);
      chk("t1_clk", clk_out, ((k % 5) < 3) ? 4'hF : 4'h0);
    end
    chk("t1_pend", div_pending, 4'h0);

    // 2: ch0 load 7 at count 1, overwritten by 3 at count 2; old period ends at edge 20
    step();                                   // edge 16, count 1
    div_load = 4'b0001; div_value = 8'd7;
    step();                                   // edge 17, count 2
    chk("t2_pend_a", div_pending, 4'b0001);
    div_value = 8'd3;
    step();                                   // edge 18, count 3
    div_load = '0;
    chk("t2_pend_b", div_pending, 4'b0001);
    step();                                   // edge 19, count 4
    chk("t2_tick_19", tick_out[0], 1'b0);
    chk("t2_pend_c", div_pending, 4'b0001);
    step();                                   // edge 20, terminal, DIV becomes 3
    chk("t2_tick_20", tick_out[0], 1'b1);
    chk("t2_pend_d", div_pending, 4'b0000);
    for (int k = 1; k <= 6; k++) begin        // edges 21..26, ch0 count k%3
      step();
      chk("t2_tick3", tick_out[0], (k % 3 == 0) ? 1'b1 : 1'b0);
      chk("t2_clk3", clk_out[0], ((k % 3) < 2) ? 1'b1 : 1'b0);
    end

    // 3: zero divisor on ch1 (count 1 -> 2 at edge 27); period stays 5
    div_load = 4'b0010; div_value = 8'd0;
    step();                                   // edge 27
    div_load = '0;
    chk("t3_err", cfg_err, 4'b0010);
    chk("t3_pend", div_pending, 4'b0000);
    step();
    step();                                   // edge 29, ch1 count 4
    chk("t3_tick_29", tick_out[1], 1'b0);
    step();                                   // edge 30
    chk("t3_tick_30", tick_out[1], 1'b1);
    repeat (5) step();                        // edge 35
    chk("t3_tick_35", tick_out[1], 1'b1);
    chk("t3_err_sticky", cfg_err, 4'b0010);

    // 4: ch2 disabled, loaded with 1, then enabled
    en = 4'b1011;
    step();                                   // edge 36
    div_load = 4'b0100; div_value = 8'd1;
    step();                                   // edge 37
    div_load = '0;
    chk("t4_tick_idle", tick_out[2], 1'b0);
    chk("t4_pend_idle", div_pending[2], 1'b0);
    en = 4'hF;
    for (int k = 0; k < 4; k++) begin         // edges 38..41
      step();
      chk("t4_tick1", tick_out[2], 1'b1);
      chk("t4_clk1", clk_out[2], 1'b1);
    end

    // 5: ch3 (DIV 5, count 1 after edge 41) paused at count 3 for 7 cycles
    step();
    step();                                   // edge 43, count 3, clk 0
    en = 4'b0111;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t5_tick_hold", tick_out[3], 1'b0);
      chk("t5_clk_hold", clk_out[3], 1'b0);
    end
    en = 4'hF;
    step();                                   // count 4
    chk("t5_tick_r1", tick_out[3], 1'b0);
    div_load = 4'b1000; div_value = 8'd2;     // load on the terminal edge
    step();
    div_load = '0;
    chk("t5_tick_r2", tick_out[3], 1'b1);
    chk("t5_pend_term", div_pending[3], 1'b0);
    step();
    chk("t5_div2_a", tick_out[3], 1'b0);
    step();
    chk("t5_div2_b", tick_out[3], 1'b1);

    // 6: ch0 <- 4, ch1 <- 6, then sync_clear aligns both
    div_load = 4'b0001; div_value = 8'd4;
    step();
    div_load = 4'b0010; div_value = 8'd6;
    step();
    div_load   = '0;
    sync_clear = 1'b1;
    step();                                   // edge S
    sync_clear = 1'b0;
    chk("t6_tick_s", tick_out, 4'h0);
    chk("t6_pend_s", div_pending, 4'h0);
    chk("t6_clk_s", clk_out[1:0], 2'b11);
    step();
    step();                                   // S+2: ch0 count 2 of 4 -> 0, ch1 2 of 6 -> 1
    chk("t6_clk_s2", clk_out[1:0], 2'b10);
    chk("t6_tick_s2", tick_out[1:0], 2'b00);
    step();
    step();                                   // S+4
    chk("t6_tick_s4", tick_out[1:0], 2'b01);
    step();
    step();                                   // S+6
    chk("t6_tick_s6", tick_out[1:0], 2'b10);
    chk("t6_ch2_tick", tick_out[2], 1'b1);

    // reset mid-period with a divisor pending on ch0 (count 2 -> 3 of 4)
    div_load = 4'b0001; div_value = 8'd2;
    step();
    div_load = '0;
    chk("rm_pend_pre", div_pending, 4'b0001);
    chk("rm_err_pre", cfg_err, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_tick", tick_out, 4'h0);
    chk("rm_clk", clk_out, 4'h0);
    chk("rm_pend", div_pending, 4'h0);
    chk("rm_err", cfg_err, 4'h0);
    #2 rst_n = 1'b1;
    repeat (4) step();
    chk("rm_tick_4", tick_out, 4'h0);
    step();
    chk("rm_tick_5", tick_out, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
